motoro3_step_sequencer: RTL
===========================

Name: motoro3_step_sequencer

Overview:
Upstream timing source for motoro3_pwm_generator. Generates the per-step position counter m3cnt, its first/last strobes and the 12-step commutation index sgStep. Also generates the PWM-active and last-step qualifiers and a shadowed pwmLENpos. Run/stop control and per-step period come from m3r_* register inputs; every output is registered.

Parameters:
CNT_W, 25, width of m3cnt and of the step period
LEN_W, 16, width of pwmLENpos
STEP_NUM, 12, number of steps per electrical cycle (sgStep 0..STEP_NUM-1; STEP_NUM must be even)
PERIOD_MIN, 4, minimum effective step period in clocks

Ports:
clk  input  1  system clock (10 MHz)
rst  input  1  synchronous reset, active-high
m3r_runEn  input  1  run request level
m3r_stepPeriod  input  CNT_W  clocks per step
m3r_pwmLENwant  input  LEN_W  position increment per PWM period
m3cnt  output  CNT_W  position within current step, counts 0..periodEff-1
m3cntFirst1  output  1  high while m3cnt==0 in RUN
m3cntFirst2  output  1  high while m3cnt==1 in RUN
m3cntLast2  output  1  high while m3cnt==periodEff-2 in RUN
m3cntLast1  output  1  high while m3cnt==periodEff-1 in RUN
sgStep  output  4  commutation step index 0..11
pwmActive1  output  1  high in RUN
pwmLastStep1  output  1  high throughout the final half-cycle of a stop sequence
pwmLENpos  output  LEN_W  shadowed m3r_pwmLENwant

Behaviour:
- Clocking/reset: one clock (clk); reset is synchronous, active-high (rst), sampled on the rising edge of clk. All state updates occur on the rising edge of clk.
- Reset values: all outputs 0; FSM=IDLE; internal periodEff=PERIOD_MIN; stopReq=0; lastHalf=0.
- FSM states: IDLE, ARM, RUN.
- IDLE: m3cnt=0, all strobes 0, pwmActive1=0, sgStep=0. m3r_runEn=1 -> ARM.
- ARM (exactly 1 cycle):
  - Latch periodEff = max(m3r_stepPeriod, PERIOD_MIN).
  - Latch pwmLENpos = m3r_pwmLENwant.
  - Go to RUN with m3cnt=0 and sgStep=0.
  - m3cntFirst1 and pwmActive1 assert in the first RUN cycle, i.e. 2 cycles after runEn is first sampled high.
- RUN counting:
  - m3cnt increments by 1 each cycle.
  - At m3cntLast1: m3cnt wraps to 0 and sgStep advances (11 -> 0).
  - periodEff and pwmLENpos re-latch only on that wrap cycle. Mid-step register changes have no effect until the next step.
- Strobes are decoded from the registered next value, so each is high for exactly one cycle per step, aligned with the matching m3cnt value. Their order within a step is First1, First2, ..., Last2, Last1, and they never overlap.
- Stop handling:
  - m3r_runEn=0 sampled in RUN sets stopReq.
  - m3r_runEn=1 with lastHalf=0 clears stopReq (stop cancelled).
  - On a wrap into sgStep 0 or 6 with stopReq=1: set lastHalf=1 and clear stopReq.
  - pwmLastStep1 = lastHalf.
  - At m3cntLast1 of sgStep 5 or 11 with lastHalf=1: go to IDLE and clear lastHalf. All outputs take their IDLE values on the next cycle.
  - A stop requested mid-half therefore completes the current half, then exactly one further half-cycle (6 steps).
- m3r_runEn reasserted while lastHalf=1 is ignored until IDLE is reached. IDLE then re-enters ARM on the next cycle if runEn is still high.
- Period clamp: m3r_stepPeriod values 0..3 are treated as 4. Width is CNT_W unsigned; no overflow is possible because m3cnt < periodEff.
- rst=1 mid-RUN forces IDLE and reset values on the same clock edge, with no drain.

Optional Feature:
MOTORO3_STEP_COUNT_EN:
- Defined: adds output port m3stepTotal [15:0]. It increments by 1 (wrapping 0xFFFF -> 0) on every RUN wrap cycle, clears to 0 on rst and in ARM, and holds its value in IDLE.
- Not defined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
1. rst=1 for 3 clks, then m3r_stepPeriod=10, runEn=1 -> First1 high at cycle 2 after runEn; Last2 at m3cnt=8; Last1 at m3cnt=9; sgStep 0->1 on the following cycle; pwmActive1=1.
2. Period=10, run 12 steps -> sgStep sequence 0..11,0. Each strobe pulses exactly 12 times; no two strobes are high together.
3. runEn dropped at sgStep=2 -> steps 2..5 complete, pwmLastStep1=1 for steps 6..11 (60 clks), IDLE after Last1 of step 11, pwmActive1=0.
4. runEn low for 5 clks during sgStep=3, then high again -> no lastHalf, sgStep continues 4,5,6,... with pwmLastStep1=0.
5. m3r_stepPeriod=2 -> effective period 4: m3cnt 0,1,2,3. m3r_stepPeriod changed 10->20 at m3cnt=5 -> current step still ends at m3cnt=9; next step ends at 19.
6. rst pulse at sgStep=7, m3cnt=4 -> next cycle all outputs 0. With MOTORO3_STEP_COUNT_EN: after 25 wraps m3stepTotal=25; it reads 0 after rst.

Source files
------------

// File: rtl/motoro3_step_sequencer.sv
// Step timing source for the motoro3 PWM generator: step counter, strobes,
// commutation index, run/stop sequencing. Optional macro: MOTORO3_STEP_COUNT_EN
// Ports: clk, rst (sync, active-high), m3r_runEn, m3r_stepPeriod,
//   m3r_pwmLENwant in; m3cnt, m3cntFirst1/2, m3cntLast2/1, sgStep,
//   pwmActive1, pwmLastStep1, pwmLENpos out (+ m3stepTotal with macro).
module motoro3_step_sequencer #(
  parameter int CNT_W      = 25,
  parameter int LEN_W      = 16,
  parameter int STEP_NUM   = 12,
  parameter int PERIOD_MIN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m3r_runEn,
  input  logic [CNT_W-1:0] m3r_stepPeriod,
  input  logic [LEN_W-1:0] m3r_pwmLENwant,
  output logic [CNT_W-1:0] m3cnt,
  output logic             m3cntFirst1,
  output logic             m3cntFirst2,
  output logic             m3cntLast2,
  output logic             m3cntLast1,
  output logic [3:0]       sgStep,
  output logic             pwmActive1,
  output logic             pwmLastStep1,
  output logic [LEN_W-1:0] pwmLENpos
`ifdef MOTORO3_STEP_COUNT_EN
  ,
  output logic [15:0]      m3stepTotal
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN
  } state_t;

  localparam logic [3:0] STEP_LAST = 4'(STEP_NUM - 1);
  localparam logic [3:0] STEP_HALF = 4'(STEP_NUM / 2);
  localparam logic [CNT_W-1:0] PMIN = CNT_W'(PERIOD_MIN);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [3:0]       step_q, step_d;
  logic [3:0]       step_nx;
  logic             stop_q, stop_d;
  logic             half_q, half_d;
  logic             act_q, act_d;
  logic             f1_q, f1_d;
  logic             f2_q, f2_d;
  logic             l2_q, l2_d;
  logic             l1_q, l1_d;
  logic [CNT_W-1:0] clamp;
`ifdef MOTORO3_STEP_COUNT_EN
  logic [15:0]      tot_q, tot_d;
`endif

  assign clamp = (m3r_stepPeriod < PMIN) ? PMIN : m3r_stepPeriod;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    len_d    = len_q;
    step_d   = step_q;
    stop_d   = stop_q;
    half_d   = half_q;
    act_d    = 1'b0;
    step_nx  = (step_q == STEP_LAST) ? 4'd0 : step_q + 4'd1;
`ifdef MOTORO3_STEP_COUNT_EN
    tot_d    = tot_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        step_d = '0;
        stop_d = 1'b0;
        half_d = 1'b0;
        if (m3r_runEn) state_d = S_ARM;
      end
      S_ARM: begin
        period_d = clamp;
        len_d    = m3r_pwmLENwant;
        cnt_d    = '0;
        step_d   = '0;
        act_d    = 1'b1;
        state_d  = S_RUN;
`ifdef MOTORO3_STEP_COUNT_EN
        tot_d    = '0;
`endif
      end
      S_RUN: begin
        act_d = 1'b1;
        if (!m3r_runEn) stop_d = 1'b1;
        else if (!half_q) stop_d = 1'b0;
        if (cnt_q == period_q - CNT_W'(1)) begin
          cnt_d    = '0;
          step_d   = step_nx;
          period_d = clamp;
          len_d    = m3r_pwmLENwant;
`ifdef MOTORO3_STEP_COUNT_EN
          tot_d    = tot_q + 16'd1;
`endif
          // final half drained: drop straight to idle values
          if (half_q && (step_q == STEP_HALF - 4'd1 ||
                         step_q == STEP_LAST)) begin
            state_d = S_IDLE;
            half_d  = 1'b0;
            stop_d  = 1'b0;
            act_d   = 1'b0;
            step_d  = '0;
          end else if (stop_q && (step_nx == 4'd0 ||
                                  step_nx == STEP_HALF)) begin
            half_d = 1'b1;
            stop_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // decode strobes from next count so they align with m3cnt
    f1_d = act_d && (cnt_d == '0);
    f2_d = act_d && (cnt_d == CNT_W'(1));
    l2_d = act_d && (cnt_d == period_d - CNT_W'(2));
    l1_d = act_d && (cnt_d == period_d - CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      period_q <= PMIN;
      len_q    <= '0;
      step_q   <= '0;
      stop_q   <= 1'b0;
      half_q   <= 1'b0;
      act_q    <= 1'b0;
      f1_q     <= 1'b0;
      f2_q     <= 1'b0;
      l2_q     <= 1'b0;
      l1_q     <= 1'b0;
`ifdef MOTORO3_STEP_COUNT_EN
      tot_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      len_q    <= len_d;
      step_q   <= step_d;
      stop_q   <= stop_d;
      half_q   <= half_d;
      act_q    <= act_d;
      f1_q     <= f1_d;
      f2_q     <= f2_d;
      l2_q     <= l2_d;
      l1_q     <= l1_d;
`ifdef MOTORO3_STEP_COUNT_EN
      tot_q    <= tot_d;
`endif
    end
  end

  assign m3cnt        = cnt_q;
  assign m3cntFirst1  = f1_q;
  assign m3cntFirst2  = f2_q;
  assign m3cntLast2   = l2_q;
  assign m3cntLast1   = l1_q;
  assign sgStep       = step_q;
  assign pwmActive1   = act_q;
  assign pwmLastStep1 = half_q;
  assign pwmLENpos    = len_q;
`ifdef MOTORO3_STEP_COUNT_EN
  assign m3stepTotal  = tot_q;
`endif

endmodule
